// File: rtl/plab4_net_router_input_queue_tp_pkg.sv
// Shared definitions for the timing-protected router input stage.
// Domain encodings and default sizing are also used by the input terminal
// control/arbiter, so both sides agree on what "D1" and "D2" mean.
package plab4_net_router_input_queue_tp_pkg;

    // Time-slot owner encoding carried on the 'domain' signal
    localparam logic DOMAIN_D1 = 1'b0;
    localparam logic DOMAIN_D2 = 1'b1;

    // Default network message width (header + payload) and per-domain depth
    localparam int MSG_NBITS_DEF   = 44;
    localparam int NUM_ENTRIES_DEF = 4;

endpackage

// File: rtl/plab4_net_queue_1dom_tp.sv
// Single-domain FIFO with time-slot gated dequeue.
//   clk, reset_n         : clock, async active-low reset
//   domain_id            : which domain this queue belongs to (tied off by parent)
//   domain               : current time-slot owner
//   in_val/in_rdy/in_msg : enqueue handshake
//   out_val/out_rdy/out_msg : head-of-queue handshake; out_val only in own slot
//   num_free             : free entries, straight from registered count
module plab4_net_queue_1dom_tp
    import plab4_net_router_input_queue_tp_pkg::*;
#(
    parameter int p_msg_nbits      = MSG_NBITS_DEF,
    parameter int p_num_entries    = NUM_ENTRIES_DEF,
    parameter int p_num_free_nbits = $clog2(p_num_entries + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        domain_id,
    input  logic                        domain,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [p_msg_nbits-1:0]      in_msg,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [p_msg_nbits-1:0]      out_msg,
    output logic [p_num_free_nbits-1:0] num_free
);

    localparam int AW = $clog2(p_num_entries);
    typedef logic [AW-1:0]               ptr_t;
    typedef logic [p_num_free_nbits-1:0] cnt_t;
    localparam cnt_t FULL = cnt_t'(p_num_entries);

    logic [p_msg_nbits-1:0] mem [p_num_entries];
    ptr_t enq_ptr, deq_ptr;
    cnt_t count;
    logic enq_fire, deq_fire;

    // Ready and valid come only from registered state: no bypass, and no
    // same-cycle full->ready path through out_rdy.
    assign in_rdy   = (count != FULL);
    assign out_val  = (count != '0) && (domain == domain_id);
    assign out_msg  = mem[deq_ptr];
    assign num_free = FULL - count;

    assign enq_fire = in_val && in_rdy;
    assign deq_fire = out_val && out_rdy;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            count   <= '0;
        end else begin
            if (enq_fire) enq_ptr <= enq_ptr + ptr_t'(1);
            if (deq_fire) deq_ptr <= deq_ptr + ptr_t'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (enq_fire) mem[enq_ptr] <= in_msg;
    end

endmodule

// File: rtl/plab4_net_router_input_queue_tp.sv
// Dual-domain router input buffer with timing-channel protection.
// Two physically separate queues; each only dequeues in its own time slot,
// so neither domain's occupancy or credits can observe the other's traffic.
//   clk, reset_n        : clock, async active-low reset
//   domain              : current time-slot owner (0 = D1, 1 = D2)
//   in_*_d0/d1          : per-domain enqueue handshake
//   out_*_d0/d1         : per-domain head-of-queue handshake (slot gated)
//   num_free_d0/d1      : per-domain free-slot counts
module plab4_net_router_input_queue_tp
    import plab4_net_router_input_queue_tp_pkg::*;
#(
    parameter int p_msg_nbits      = MSG_NBITS_DEF,
    parameter int p_num_entries    = NUM_ENTRIES_DEF,
    parameter int p_num_free_nbits = $clog2(p_num_entries + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        domain,
    input  logic                        in_val_d0,
    output logic                        in_rdy_d0,
    input  logic [p_msg_nbits-1:0]      in_msg_d0,
    input  logic                        in_val_d1,
    output logic                        in_rdy_d1,
    input  logic [p_msg_nbits-1:0]      in_msg_d1,
    output logic                        out_val_d0,
    input  logic                        out_rdy_d0,
    output logic [p_msg_nbits-1:0]      out_msg_d0,
    output logic                        out_val_d1,
    input  logic                        out_rdy_d1,
    output logic [p_msg_nbits-1:0]      out_msg_d1,
    output logic [p_num_free_nbits-1:0] num_free_d0,
    output logic [p_num_free_nbits-1:0] num_free_d1
);

    plab4_net_queue_1dom_tp #(
        .p_msg_nbits      (p_msg_nbits),
        .p_num_entries    (p_num_entries),
        .p_num_free_nbits (p_num_free_nbits)
    ) u_q_d0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .domain_id (DOMAIN_D1),
        .domain    (domain),
        .in_val    (in_val_d0),
        .in_rdy    (in_rdy_d0),
        .in_msg    (in_msg_d0),
        .out_val   (out_val_d0),
        .out_rdy   (out_rdy_d0),
        .out_msg   (out_msg_d0),
        .num_free  (num_free_d0)
    );

    plab4_net_queue_1dom_tp #(
        .p_msg_nbits      (p_msg_nbits),
        .p_num_entries    (p_num_entries),
        .p_num_free_nbits (p_num_free_nbits)
    ) u_q_d1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .domain_id (DOMAIN_D2),
        .domain    (domain),
        .in_val    (in_val_d1),
        .in_rdy    (in_rdy_d1),
        .in_msg    (in_msg_d1),
        .out_val   (out_val_d1),
        .out_rdy   (out_rdy_d1),
        .out_msg   (out_msg_d1),
        .num_free  (num_free_d1)
    );

endmodule

// File: tb/tb_plab4_net_router_input_queue_tp.sv
module tb_plab4_net_router_input_queue_tp;

    localparam int MW = 44;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          domain;
    logic          in_val_d0, in_val_d1, out_rdy_d0, out_rdy_d1;
    logic          in_rdy_d0, in_rdy_d1, out_val_d0, out_val_d1;
    logic [MW-1:0] in_msg_d0, in_msg_d1, out_msg_d0, out_msg_d1;
    logic [2:0]    num_free_d0, num_free_d1;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] rec [20];

    plab4_net_router_input_queue_tp dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .domain      (domain),
        .in_val_d0   (in_val_d0),
        .in_rdy_d0   (in_rdy_d0),
        .in_msg_d0   (in_msg_d0),
        .in_val_d1   (in_val_d1),
        .in_rdy_d1   (in_rdy_d1),
        .in_msg_d1   (in_msg_d1),
        .out_val_d0  (out_val_d0),
        .out_rdy_d0  (out_rdy_d0),
        .out_msg_d0  (out_msg_d0),
        .out_val_d1  (out_val_d1),
        .out_rdy_d1  (out_rdy_d1),
        .out_msg_d1  (out_msg_d1),
        .num_free_d0 (num_free_d0),
        .num_free_d1 (num_free_d1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs/outputs are touched 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_val_d0 = 0; in_val_d1 = 0; out_rdy_d0 = 0; out_rdy_d1 = 0;
        in_msg_d0 = '0; in_msg_d1 = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        tick();
        reset_n = 1;
        #1;
    endtask

    // One isolation run: identical D1 stimulus; D2 either idle or saturated.
    task automatic iso_run(input bit busy, input bit record);
        do_reset();
        for (int c = 0; c < 24; c++) begin
            int k;
            k = c - 4;
            if (c < 4) begin
                domain = 1'b1; in_val_d0 = 0; out_rdy_d0 = 0; in_msg_d0 = '0;
            end else begin
                domain     = k[2];
                in_val_d0  = (k % 3 != 2);
                in_msg_d0  = MW'(32'h100 + k);
                out_rdy_d0 = (k % 4 != 1);
            end
            in_val_d1  = busy;
            in_msg_d1  = MW'($urandom);
            out_rdy_d1 = busy ? 1'($urandom_range(1, 0)) : 1'b0;
            #1;
            if (c >= 4) begin
                logic [63:0] s;
                s = {15'd0, out_val_d0, in_rdy_d0, num_free_d0,
                     out_val_d0 ? out_msg_d0 : {MW{1'b0}}};
                if (record) rec[k] = s;
                else chk($sformatf("iso_c%0d", k), s, rec[k]);
            end
            tick();
        end
        if (busy) chk("iso_d2_full", {61'd0, num_free_d1}, 64'd0);
    endtask

    initial begin
        logic [MW-1:0] q [$];
        logic [MW-1:0] fill [4];
        fill[0] = 44'h11; fill[1] = 44'h22; fill[2] = 44'h33; fill[3] = 44'h44;

        idle();
        domain  = 1'b0;
        reset_n = 0;
        #2;
        chk("rst_in_rdy0",   {63'd0, in_rdy_d0},   64'd1);
        chk("rst_in_rdy1",   {63'd0, in_rdy_d1},   64'd1);
        chk("rst_out_val0",  {63'd0, out_val_d0},  64'd0);
        chk("rst_num_free0", {61'd0, num_free_d0}, 64'd4);
        chk("rst_num_free1", {61'd0, num_free_d1}, 64'd4);
        tick();
        reset_n = 1;
        #1;

        // Mid-traffic async reset with 3 entries in D1
        domain = 0;
        in_val_d0 = 1;
        for (int i = 0; i < 3; i++) begin
            in_msg_d0 = MW'(8'hA0 + i);
            tick();
        end
        in_val_d0 = 0;
        #1;
        chk("pre_rst_free", {61'd0, num_free_d0}, 64'd1);
        chk("pre_rst_val",  {63'd0, out_val_d0},  64'd1);
        reset_n = 0;
        #1;
        chk("arst_in_rdy",  {63'd0, in_rdy_d0},   64'd1);
        chk("arst_out_val", {63'd0, out_val_d0},  64'd0);
        chk("arst_free",    {61'd0, num_free_d0}, 64'd4);
        tick();
        reset_n = 1;
        tick();
        chk("post_rst_val",  {63'd0, out_val_d0},  64'd0);
        chk("post_rst_free", {61'd0, num_free_d0}, 64'd4);

        // Fill D1 then drain in order
        domain = 0; out_rdy_d0 = 0; in_val_d0 = 1;
        for (int i = 0; i < 4; i++) begin
            in_msg_d0 = fill[i];
            tick();
            chk($sformatf("fill_free%0d", i), {61'd0, num_free_d0}, 64'(3 - i));
        end
        chk("full_in_rdy", {63'd0, in_rdy_d0}, 64'd0);
        in_msg_d0 = 44'h99;
        tick();
        chk("full_hold_free", {61'd0, num_free_d0}, 64'd0);
        in_val_d0 = 0; out_rdy_d0 = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("drain_val%0d", i), {63'd0, out_val_d0}, 64'd1);
            chk($sformatf("drain_msg%0d", i), 64'(out_msg_d0), 64'(fill[i]));
            tick();
        end
        chk("drain_empty_val",  {63'd0, out_val_d0},  64'd0);
        chk("drain_empty_free", {61'd0, num_free_d0}, 64'd4);
        out_rdy_d0 = 0;

        // Slot gating on D2
        domain = 0; in_val_d1 = 1;
        in_msg_d1 = 44'hA1; tick();
        in_msg_d1 = 44'hA2; tick();
        in_val_d1 = 0; out_rdy_d1 = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("gate_val%0d", i),  {63'd0, out_val_d1},  64'd0);
            chk($sformatf("gate_free%0d", i), {61'd0, num_free_d1}, 64'd2);
            tick();
        end
        domain = 1;
        #1;
        chk("slot_msg0", 64'(out_msg_d1), 64'hA1);
        tick();
        chk("slot_msg1", 64'(out_msg_d1), 64'hA2);
        tick();
        chk("slot_empty", {63'd0, out_val_d1},  64'd0);
        chk("slot_free",  {61'd0, num_free_d1}, 64'd4);

        // Simultaneous enq/deq on D2 at count 2, pointers wrapping
        out_rdy_d1 = 0; in_val_d1 = 1;
        for (int i = 0; i < 2; i++) begin
            in_msg_d1 = MW'(8'hB0 + i); q.push_back(in_msg_d1);
            tick();
        end
        out_rdy_d1 = 1;
        for (int i = 2; i < 8; i++) begin
            in_msg_d1 = MW'(8'hB0 + i); q.push_back(in_msg_d1);
            #1;
            chk($sformatf("sim_free%0d", i), {61'd0, num_free_d1}, 64'd2);
            chk($sformatf("sim_msg%0d", i),  64'(out_msg_d1), 64'(q.pop_front()));
            tick();
        end
        in_val_d1 = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("sim_tail%0d", i), 64'(out_msg_d1), 64'(q.pop_front()));
            tick();
        end
        chk("sim_empty", {63'd0, out_val_d1}, 64'd0);
        out_rdy_d1 = 0;

        // No bypass: enqueue at N visible at N+1
        domain = 0; out_rdy_d0 = 1; in_val_d0 = 1; in_msg_d0 = 44'h55;
        #1;
        chk("nobyp_val_n", {63'd0, out_val_d0}, 64'd0);
        tick();
        in_val_d0 = 0;
        #1;
        chk("nobyp_val_n1", {63'd0, out_val_d0}, 64'd1);
        chk("nobyp_msg_n1", 64'(out_msg_d0), 64'h55);
        tick();
        chk("nobyp_after", {63'd0, out_val_d0}, 64'd0);

        // Isolation: D1 must behave identically regardless of D2 traffic
        iso_run(1'b0, 1'b1);
        iso_run(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
